// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - instruction-fetch stage: PC, IF/ID register, stall/redirect/halt, wrap pulse
module fetch_unit #(
  parameter int                   PC_W      = 8,
  parameter int                   INSTR_W   = 24,
  parameter logic [PC_W-1:0]      RESET_PC  = 8'h00,
  parameter logic [INSTR_W-1:0]   NOP_INSTR = 24'h0,
  parameter int                   CNT_W     = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               stall_i,
  input  logic               redirect_i,
  input  logic [PC_W-1:0]    redirect_pc_i,
  input  logic               halt_i,
  output logic [PC_W-1:0]    imem_pc_o,
  input  logic [INSTR_W-1:0] imem_instr_i,
  output logic               ifid_valid_o,
  output logic [PC_W-1:0]    ifid_pc_o,
  output logic [PC_W-1:0]    ifid_pc_next_o,
  output logic [INSTR_W-1:0] ifid_instr_o,
  output logic               halted_o,
  output logic               pc_wrap_o,
  output logic [CNT_W-1:0]   fetch_count_o
);

  typedef enum logic {RUN, HALTED} state_t;

  state_t          state_q;
  logic [PC_W-1:0] pc_q;

  assign imem_pc_o      = pc_q;
  assign ifid_pc_next_o = ifid_pc_o + 1'b1;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= RUN;
      pc_q          <= RESET_PC;
      ifid_valid_o  <= 1'b0;
      ifid_pc_o     <= '0;
      ifid_instr_o  <= NOP_INSTR;
      halted_o      <= 1'b0;
      pc_wrap_o     <= 1'b0;
      fetch_count_o <= '0;
    end else begin
      pc_wrap_o <= 1'b0;
      if (redirect_i) begin
        // Wrong-path fetch is squashed into a bubble and not counted.
        pc_q         <= redirect_pc_i;
        ifid_valid_o <= 1'b0;
        ifid_pc_o    <= '0;
        ifid_instr_o <= NOP_INSTR;
        state_q      <= RUN;
        halted_o     <= 1'b0;
      end else if (halt_i || state_q == HALTED) begin
        ifid_valid_o <= 1'b0;
        ifid_pc_o    <= '0;
        ifid_instr_o <= NOP_INSTR;
        state_q      <= HALTED;
        halted_o     <= 1'b1;
      end else if (!stall_i) begin
        pc_q         <= pc_q + 1'b1;
        ifid_valid_o <= 1'b1;
        ifid_pc_o    <= pc_q;
        ifid_instr_o <= imem_instr_i;
        pc_wrap_o    <= (pc_q == {PC_W{1'b1}});
        if (fetch_count_o != {CNT_W{1'b1}})
          fetch_count_o <= fetch_count_o + 1'b1;
      end
    end
  end

endmodule
